load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store stage between the single-cycle Datapath and a handshaked data memory.
//  Takes address, store data, Funct3 and MemRead/MemWrite from the Datapath.
//  Aligns byte/half/word accesses onto a 32-bit word bus with byte enables, and sign/zero-extends load data.
//  Holds stall high so the Datapath freezes its PC until the access completes.
// PARAMETERS
//  DATA_W      32   data width (fixed at 32; byte lanes assume 4 bytes)
//  DM_ADDRESS  9    byte-address width into data memory
//  TIMEOUT     15   max WAIT cycles without mem_ack before bus error (>=1)
//  TO_W        4    timeout counter width, must hold TIMEOUT
// PORTS
//  clk        in   1           clock; all state changes on rising edge
//  reset      in   1           synchronous, active-high
//  MemRead    in   1           load request from Datapath
//  MemWrite   in   1           store request from Datapath
//  Funct3     in   3           000 b, 001 h, 010 w, 100 bu, 101 hu
//  addr       in   DM_ADDRESS  byte address (ALU result)
//  wdata      in   DATA_W      store data (Reg2)
//  rdata      out  DATA_W      extended load data to writeback mux
//  stall      out  1           freeze PC/regfile write while high
//  err        out  1           one-cycle pulse: access failed
//  mem_req    out  1           memory request, held until ack
//  mem_we     out  1           1 = write
//  mem_addr   out  DM_ADDRESS  word-aligned address {addr[DM_ADDRESS-1:2],2'b00}
//  mem_be     out  4           byte enables
//  mem_wdata  out  DATA_W      lane-replicated store data
//  mem_rdata  in   DATA_W      read word; valid when mem_ack
//  mem_ack    in   1           access complete; sampled only in WAIT
// BEHAVIOUR
//  Reset: state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata, err, timeout counter = 0.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//   IDLE, MemRead|MemWrite: stall=1 (combinational).
//     Latch addr, Funct3 and aligned wdata/be.
//     Next edge: mem_req=1, mem_we=MemWrite, go WAIT.
//   IDLE, no request: stall=0.
//   WAIT: stall=1, mem_req held, counter increments.
//     mem_ack: capture extended rdata, drop mem_req, go DONE.
//     counter reaches TIMEOUT with no ack: drop mem_req, rdata=0, err=1, go DONE.
//     ack in the expiry cycle wins over timeout.
//   DONE: stall=0 for exactly 1 cycle, so the Datapath commits.
//     err cleared on exit. Always returns to IDLE; next instruction's request is seen in IDLE.
//  Latency: load/store with ack in WAIT cycle k -> stall high k+1 cycles, then DONE.
//  MemRead & MemWrite both high: treated as a store.
//  mem_ack outside WAIT: ignored.
//  Reset mid-access: IDLE next cycle, mem_req=0, a late ack is ignored.
//  Store lanes:
//    sb: be=0001<<addr[1:0], byte replicated x4.
//    sh: be=0011<<{addr[1],1'b0}, half replicated x2.
//    sw: be=1111.
//  Load select:
//    b/bu: byte addr[1:0], sign bit 7 / zero-extend.
//    h/hu: half addr[1], sign bit 15 / zero-extend.
//    w: whole word.
//  rdata holds its value until the next completed load or err.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    Misaligned accesses are h/hu/sh with addr[0]=1, or w/sw with addr[1:0]!=0.
//    These issue no mem_req: IDLE -> DONE directly, err=1, rdata=0.
//  MISALIGN_TRAP_EN undefined: offending low address bits are ignored; access proceeds normally.
// TESTING
//  1. lb addr 0x003, ack in 2nd WAIT cycle, mem_rdata 0x80FF1234 -> rdata 0xFFFFFF80, stall high 3 cycles, err 0.
//  2. sh addr 0x006, wdata 0x0000ABCD -> mem_addr 0x004, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1.
//  3. lw, no ack, TIMEOUT=15 -> mem_req drops after 15 WAIT cycles, err=1 for 1 cycle, rdata 0x00000000.
//  4. reset asserted in WAIT, ack next cycle -> mem_req 0, state IDLE, rdata unchanged (0).
//  5. lw addr 0x002: with MISALIGN_TRAP_EN -> no mem_req, err=1; without -> mem_addr 0x000, mem_be 1111.
//  6. back-to-back lbu 0x001 then lw 0x008, ack 1 cycle each -> rdata 0x000000xx then the full word, stall low exactly 1 cycle between.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store stage with byte-lane alignment and handshaked memory port
// Optional MISALIGN_TRAP_EN: misaligned h/hu/sh/w/sw accesses skip the bus and report err.
module load_store_unit #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int TIMEOUT    = 15,
    parameter int TO_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  stall,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state, state_n;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [TO_W-1:0]   cnt;
    logic              req_any;
    logic              misalign;
    logic              timeout_hit;
    logic [3:0]        be_a;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] byte_sh;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] ld_ext;

    assign req_any     = MemRead | MemWrite;
    assign timeout_hit = (cnt == TO_W'(TIMEOUT - 1));

    // Funct3[1:0] encodes size; 11 is not a legal size and falls back to a word
    always_comb begin
        be_a    = 4'b1111;
        wdata_a = wdata;
        case (Funct3[1:0])
            2'b00: begin
                be_a    = 4'b0001 << addr[1:0];
                wdata_a = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_a    = 4'b0011 << {addr[1], 1'b0};
                wdata_a = {2{wdata[15:0]}};
            end
            default: begin
                be_a    = 4'b1111;
                wdata_a = wdata;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((Funct3[1:0] == 2'b01) && addr[0]) ||
                      ((Funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Load extraction uses the offset and size latched at request time
    always_comb begin
        byte_sh  = mem_rdata >> {off_q, 3'b000};
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   ld_ext = {{24{byte_sh[7] & ~f3_q[2]}}, byte_sh[7:0]};
            2'b01:   ld_ext = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    stall   = 1'b1;
                    state_n = misalign ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_ack || timeout_hit) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        f3_q      <= Funct3;
                        off_q     <= addr[1:0];
                        mem_addr  <= {addr[DM_ADDRESS-1:2], 2'b00};
                        mem_be    <= be_a;
                        mem_wdata <= wdata_a;
                        cnt       <= '0;
                        if (misalign) begin
                            err   <= 1'b1;
                            rdata <= '0;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= MemWrite;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            rdata <= ld_ext;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        rdata   <= '0;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall, err, mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    int stall_cnt, req_cnt;
    logic        snap_we;
    logic [8:0]  snap_addr;
    logic [3:0]  snap_be;
    logic [31:0] snap_wdata;

    load_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request, raises ack in WAIT cycle ack_k (0 = never), returns in the cycle stall drops
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] wd, input int ack_k, input logic [31:0] rw);
        MemRead  = rd;
        MemWrite = wr;
        Funct3   = f3;
        addr     = a;
        wdata    = wd;
        #1;
        stall_cnt  = 0;
        req_cnt    = 0;
        snap_we    = 1'bx;
        snap_addr  = 'x;
        snap_be    = 'x;
        snap_wdata = 'x;
        for (int c = 0; c < 40 && stall; c++) begin
            stall_cnt++;
            if (mem_req) req_cnt++;
            if (c == 1) begin
                snap_we    = mem_we;
                snap_addr  = mem_addr;
                snap_be    = mem_be;
                snap_wdata = mem_wdata;
            end
            mem_ack   = (ack_k != 0) && (c == ack_k);
            mem_rdata = rw;
            tick();
        end
        mem_ack  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; MemRead = 0; MemWrite = 0; Funct3 = 0; addr = 0; wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        tick(); tick();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        tick();

        // lb 0x003, ack in 2nd WAIT cycle
        access(1, 0, 3'b000, 9'h003, 0, 2, 32'h80FF1234);
        chk("lb_stall", stall_cnt, 3);
        chk("lb_req_cycles", req_cnt, 2);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        chk("lb_err", {31'd0, err}, 32'd0);
        chk("lb_done_req", {31'd0, mem_req}, 32'd0);
        tick();

        // sh 0x006
        access(0, 1, 3'b001, 9'h006, 32'h0000ABCD, 1, 32'hDEADBEEF);
        chk("sh_addr", {23'd0, snap_addr}, 32'h004);
        chk("sh_be", {28'd0, snap_be}, 32'hC);
        chk("sh_wdata", snap_wdata, 32'hABCDABCD);
        chk("sh_we", {31'd0, snap_we}, 32'd1);
        chk("sh_rdata_hold", rdata, 32'hFFFFFF80);
        tick();

        // sb 0x005 with both MemRead and MemWrite: store wins
        access(1, 1, 3'b000, 9'h005, 32'h1234565A, 1, 32'h0);
        chk("sb_we", {31'd0, snap_we}, 32'd1);
        chk("sb_be", {28'd0, snap_be}, 32'h2);
        chk("sb_wdata", snap_wdata, 32'h5A5A5A5A);
        tick();

        // lh / lhu upper half
        access(1, 0, 3'b001, 9'h00E, 0, 1, 32'h80011234);
        chk("lh_rdata", rdata, 32'hFFFF8001);
        chk("lh_be", {28'd0, snap_be}, 32'hC);
        tick();
        access(1, 0, 3'b101, 9'h00E, 0, 1, 32'h80011234);
        chk("lhu_rdata", rdata, 32'h00008001);
        tick();

        // back-to-back lbu 0x001 then lw 0x008
        access(1, 0, 3'b100, 9'h001, 0, 1, 32'hA1B2C3D4);
        chk("b2b_lbu_rdata", rdata, 32'h000000C3);
        chk("b2b_lbu_stall", stall_cnt, 2);
        tick();
        access(1, 0, 3'b010, 9'h008, 0, 1, 32'h12345678);
        chk("b2b_lw_stall", stall_cnt, 2);
        chk("b2b_lw_addr", {23'd0, snap_addr}, 32'h008);
        chk("b2b_lw_rdata", rdata, 32'h12345678);
        tick();

        // lw with no ack: timeout
        access(1, 0, 3'b010, 9'h010, 0, 0, 32'hFFFFFFFF);
        chk("to_stall", stall_cnt, 16);
        chk("to_req_cycles", req_cnt, 15);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rdata", rdata, 32'd0);
        chk("to_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("to_err_clear", {31'd0, err}, 32'd0);

        // ack in the expiry cycle beats timeout
        access(1, 0, 3'b010, 9'h010, 0, 15, 32'hCAFEF00D);
        chk("exp_ack_err", {31'd0, err}, 32'd0);
        chk("exp_ack_rdata", rdata, 32'hCAFEF00D);
        tick();

        // misaligned lw 0x002
        access(1, 0, 3'b010, 9'h002, 0, 1, 32'h55667788);
`ifdef MISALIGN_TRAP_EN
        chk("mis_stall", stall_cnt, 1);
        chk("mis_req_cycles", req_cnt, 0);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_rdata", rdata, 32'd0);
`else
        chk("mis_addr", {23'd0, snap_addr}, 32'h000);
        chk("mis_be", {28'd0, snap_be}, 32'hF);
        chk("mis_err", {31'd0, err}, 32'd0);
        chk("mis_rdata", rdata, 32'h55667788);
`endif
        tick();

        // reset while in WAIT, late ack ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        MemRead = 1; Funct3 = 3'b010; addr = 9'h020;
        tick();
        chk("rw_wait_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        MemRead = 0;
        mem_ack = 1'b1;
        mem_rdata = 32'h99999999;
        #1;
        chk("rw_req", {31'd0, mem_req}, 32'd0);
        chk("rw_stall", {31'd0, stall}, 32'd0);
        tick();
        mem_ack = 1'b0;
        chk("rw_rdata", rdata, 32'd0);
        chk("rw_req_after", {31'd0, mem_req}, 32'd0);
        chk("rw_err", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
